// File: rtl/lepton_vospi_pkg.sv
// lepton_vospi_pkg: shared types and constants for the VoSPI receiver.
// ID word field positions and the receive FSM state type.
package lepton_vospi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESYNC,
    S_ID,
    S_CRC,
    S_PAYLOAD
  } vospi_state_t;

  localparam logic [3:0] DISCARD_NIBBLE = 4'hF;
  localparam int SEG_ID_LINE = 20;
  localparam int HDR_WORDS = 2;

  localparam int LINE_HI = 11;
  localparam int LINE_LO = 0;
  localparam int TTT_HI = 14;
  localparam int TTT_LO = 12;
  localparam int DISC_HI = 11;
  localparam int DISC_LO = 8;

endpackage

// File: rtl/lepton_vospi_rx_if.sv
// lepton_vospi_rx_if: pixel write port and segment status strobes.
// The receiver drives master; the staging buffer listens on slave.
interface lepton_vospi_rx_if #(
  parameter int LW = 6,
  parameter int CW = 7
);
  logic          pix_we;
  logic [LW-1:0] pix_line;
  logic [CW-1:0] pix_col;
  logic [15:0]   pix_data;
  logic          seg_commit;
  logic          seg_abort;
  logic [2:0]    seg_num;
  logic          resync;

  modport master (
    output pix_we, pix_line, pix_col, pix_data,
    output seg_commit, seg_abort, seg_num, resync
  );

  modport slave (
    input pix_we, pix_line, pix_col, pix_data,
    input seg_commit, seg_abort, seg_num, resync
  );
endinterface

// File: rtl/vospi_spi_shift.sv
// vospi_spi_shift: SPI mode 3 clock/CS generator and 16-bit shifter.
// Clocks only while run is high; word_done follows the 16th rise.
module vospi_spi_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        miso,
  output logic        sclk,
  output logic        cs,
  output logic        word_done,
  output logic [15:0] word
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic [3:0]    bitc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cs        <= 1'b1;
      sclk      <= 1'b1;
      div       <= '0;
      bitc      <= '0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (!run) begin
        cs   <= 1'b1;
        sclk <= 1'b1;
        div  <= '0;
        bitc <= '0;
      end else if (cs) begin
        // a full half-period of CS low precedes the first fall
        cs  <= 1'b0;
        div <= '0;
      end else if (div == DW'(CLK_DIV - 1)) begin
        div  <= '0;
        sclk <= ~sclk;
        if (!sclk) begin
          word      <= {word[14:0], miso};
          bitc      <= bitc + 4'd1;
          word_done <= (bitc == 4'd15);
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/lepton_vospi_rx.sv
// lepton_vospi_rx: VoSPI deframer for Lepton 2.x/3.x sensors.
// Tracks line/segment numbering and streams pixels to a staging buffer.
module lepton_vospi_rx
  import lepton_vospi_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int PAYLOAD_WORDS = 80,
  parameter int LINES_PER_SEG = 60,
  parameter int SEGMENTS      = 4,
  parameter int RESYNC_CYCLES = 18500000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic spi_miso,
  output logic spi_clk,
  output logic spi_cs,
  lepton_vospi_rx_if.master px
);
  localparam int LW = (LINES_PER_SEG > 1) ? $clog2(LINES_PER_SEG) : 1;
  localparam int CW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int RW = $clog2(RESYNC_CYCLES + 1);

  vospi_state_t  state;
  logic [LW-1:0] exp_line;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          discard;
  logic          drop;
  logic          run;
  logic          word_done;
  logic [15:0]   word;
  logic [11:0]   w_line;
  logic [2:0]    w_ttt;
  logic [3:0]    w_disc;
  logic          is_disc;
  logic          is_seg_line;
  logic          bad_id;

  assign run = (state == S_ID) || (state == S_CRC) ||
               (state == S_PAYLOAD);

  vospi_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .miso      (spi_miso),
    .sclk      (spi_clk),
    .cs        (spi_cs),
    .word_done (word_done),
    .word      (word)
  );

  assign w_line  = word[LINE_HI:LINE_LO];
  assign w_ttt   = word[TTT_HI:TTT_LO];
  assign w_disc  = word[DISC_HI:DISC_LO];
  assign is_disc = (w_disc == DISCARD_NIBBLE);
  assign is_seg_line = (SEGMENTS > 1) &&
                       (12'(exp_line) == 12'(SEG_ID_LINE));
  assign bad_id = !is_disc &&
                  ((w_line != 12'(exp_line)) ||
                   (is_seg_line && (int'(w_ttt) > SEGMENTS)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      exp_line      <= '0;
      cnt           <= '0;
      rcnt          <= '0;
      discard       <= 1'b0;
      drop          <= 1'b0;
      px.pix_we     <= 1'b0;
      px.pix_line   <= '0;
      px.pix_col    <= '0;
      px.pix_data   <= '0;
      px.seg_commit <= 1'b0;
      px.seg_abort  <= 1'b0;
      px.seg_num    <= '0;
      px.resync     <= 1'b0;
    end else begin
      px.pix_we     <= 1'b0;
      px.seg_commit <= 1'b0;
      px.seg_abort  <= 1'b0;
      px.resync     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_RESYNC;
            rcnt  <= '0;
          end
        end
        S_RESYNC: begin
          if (rcnt == RW'(RESYNC_CYCLES - 1)) begin
            state    <= S_ID;
            rcnt     <= '0;
            exp_line <= '0;
            drop     <= 1'b0;
            discard  <= 1'b0;
            cnt      <= '0;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        S_ID: begin
          if (word_done) begin
            if (bad_id) begin
              // a partly written segment must be dropped downstream
              px.resync    <= 1'b1;
              px.seg_abort <= (exp_line != '0);
              state        <= S_RESYNC;
              rcnt         <= '0;
            end else begin
              state   <= S_CRC;
              discard <= is_disc;
              if (!is_disc && is_seg_line) begin
                px.seg_num <= w_ttt;
                if (w_ttt == 3'd0) drop <= 1'b1;
              end
              if (!is_disc && SEGMENTS == 1) px.seg_num <= 3'd1;
            end
          end
        end
        S_CRC: begin
          if (word_done) state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (word_done) begin
            if (!discard) begin
              px.pix_we   <= 1'b1;
              px.pix_line <= exp_line;
              px.pix_col  <= cnt;
              px.pix_data <= word;
            end
            if (cnt == CW'(PAYLOAD_WORDS - 1)) begin
              cnt   <= '0;
              state <= enable ? S_ID : S_IDLE;
              if (!discard) begin
                if (exp_line == LW'(LINES_PER_SEG - 1)) begin
                  px.seg_commit <= !drop;
                  px.seg_abort  <= drop;
                  exp_line      <= '0;
                  drop          <= 1'b0;
                end else begin
                  exp_line <= exp_line + LW'(1);
                end
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
